// File: rtl/atmega_spi_s.sv
// atmega_spi_s: SPI slave with an AVR-style SPCR/SPSR/SPDR register window.
// Supports CPHA=0 only, with CPOL and DORD selectable.
//
// Ports
//   clk, rst          system clock; synchronous active-high reset
//   addr, wr, rd      register select and write/read strobes
//   bus_in, bus_out   write data; read data (0 when rd is low or addr unmatched)
//   spi_int           interrupt request (SPIF & SPIE)
//   int_rst           interrupt acknowledge, clears SPIF and WCOL
//   sck, ss, mosi     SPI slave inputs (ss active low), asynchronous to clk
//   miso, miso_oe     SPI slave output and its driver enable
//
// State | Meaning
// IDLE  | no transfer in progress; waiting for ss to fall while SPE=1
// SHIFT | ss low; bytes are shifted in/out on sck edges
module atmega_spi_s #(
    parameter int BUS_ADDR_IO_LEN = 6,
    parameter int SPCR_ADDR       = 0,
    parameter int SPSR_ADDR       = 1,
    parameter int SPDR_ADDR       = 2,
    parameter int SYNC_STAGES     = 2
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [BUS_ADDR_IO_LEN-1:0] addr,
    input  logic                       wr,
    input  logic                       rd,
    input  logic [7:0]                 bus_in,
    output logic [7:0]                 bus_out,
    output logic                       spi_int,
    input  logic                       int_rst,
    input  logic                       sck,
    input  logic                       ss,
    input  logic                       mosi,
    output logic                       miso,
    output logic                       miso_oe
);

    localparam logic [BUS_ADDR_IO_LEN-1:0] A_SPCR = BUS_ADDR_IO_LEN'(SPCR_ADDR);
    localparam logic [BUS_ADDR_IO_LEN-1:0] A_SPSR = BUS_ADDR_IO_LEN'(SPSR_ADDR);
    localparam logic [BUS_ADDR_IO_LEN-1:0] A_SPDR = BUS_ADDR_IO_LEN'(SPDR_ADDR);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [7:0] spcr_q, spcr_d;
    logic       spif_q, spif_d;
    logic       wcol_q, wcol_d;
    logic       armed_q, armed_d;
    logic [7:0] tx_buf_q, tx_buf_d;
    logic [7:0] rx_buf_q, rx_buf_d;
    logic [7:0] tx_shift_q, tx_shift_d;
    logic [7:0] rx_shift_q, rx_shift_d;
    logic [2:0] bit_cnt_q, bit_cnt_d;

    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] ss_sync_q, ss_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sck_prev_q, sck_prev_d;
    logic                   ss_prev_q, ss_prev_d;

    logic       sck_s, ss_s, mosi_s;
    logic       sck_rise, sck_fall, ss_fall, ss_rise;
    logic       lead_edge, trail_edge;
    logic       spie, spe, dord, cpol;
    logic       sel_spcr, sel_spsr, sel_spdr;
    logic       spdr_access, busy;
    logic [7:0] rx_next;

    assign spie = spcr_q[7];
    assign spe  = spcr_q[6];
    assign dord = spcr_q[5];
    assign cpol = spcr_q[3];

    // mosi goes through the same depth as sck, so mosi_s is the level that
    // was on the pin when the synchronized sck edge happened.
    assign sck_s  = sck_sync_q[SYNC_STAGES-1];
    assign ss_s   = ss_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    assign sck_rise   = sck_s & ~sck_prev_q;
    assign sck_fall   = ~sck_s & sck_prev_q;
    assign ss_fall    = ~ss_s & ss_prev_q;
    assign ss_rise    = ss_s & ~ss_prev_q;
    assign lead_edge  = cpol ? sck_fall : sck_rise;
    assign trail_edge = cpol ? sck_rise : sck_fall;

    assign sel_spcr    = (addr == A_SPCR);
    assign sel_spsr    = (addr == A_SPSR);
    assign sel_spdr    = (addr == A_SPDR);
    assign spdr_access = (rd | wr) & sel_spdr;
    assign busy        = (state_q == SHIFT) && (bit_cnt_q != 3'd0);

    assign rx_next = dord ? {mosi_s, rx_shift_q[7:1]} : {rx_shift_q[6:0], mosi_s};

    always_comb begin
        state_d     = state_q;
        spcr_d      = spcr_q;
        spif_d      = spif_q;
        wcol_d      = wcol_q;
        armed_d     = armed_q;
        tx_buf_d    = tx_buf_q;
        rx_buf_d    = rx_buf_q;
        tx_shift_d  = tx_shift_q;
        rx_shift_d  = rx_shift_q;
        bit_cnt_d   = bit_cnt_q;
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], sck};
        ss_sync_d   = {ss_sync_q[SYNC_STAGES-2:0], ss};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sck_prev_d  = sck_s;
        ss_prev_d   = ss_s;

        if (wr && sel_spcr) begin
            spcr_d = bus_in;
        end

        // Flag clears come first so that the set paths below win a tie.
        if (rd && sel_spsr && spif_q) begin
            armed_d = 1'b1;
        end
        if (spdr_access && armed_q) begin
            spif_d  = 1'b0;
            wcol_d  = 1'b0;
            armed_d = 1'b0;
        end
        if (int_rst) begin
            spif_d = 1'b0;
            wcol_d = 1'b0;
        end

        if (wr && sel_spdr) begin
            if (busy) begin
                wcol_d = 1'b1;
            end else begin
                tx_buf_d = bus_in;
            end
        end

        case (state_q)
            IDLE: begin
                if (spe && ss_fall) begin
                    state_d    = SHIFT;
                    bit_cnt_d  = 3'd0;
                    tx_shift_d = tx_buf_q;
                end
            end
            SHIFT: begin
                if (!spe || ss_rise) begin
                    state_d   = IDLE;
                    bit_cnt_d = 3'd0;
                end else if (lead_edge) begin
                    rx_shift_d = rx_next;
                    bit_cnt_d  = bit_cnt_q + 3'd1;
                    if (bit_cnt_q == 3'd7) begin
                        rx_buf_d = rx_next;
                        spif_d   = 1'b1;
                    end
                end else if (trail_edge) begin
                    // A trailing edge with bit_cnt=0 can only follow a completed
                    // byte, so it is where the next byte gets loaded.
                    if (bit_cnt_q == 3'd0) begin
                        tx_shift_d = tx_buf_q;
                    end else if (dord) begin
                        tx_shift_d = {1'b0, tx_shift_q[7:1]};
                    end else begin
                        tx_shift_d = {tx_shift_q[6:0], 1'b0};
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            spcr_q      <= 8'h00;
            spif_q      <= 1'b0;
            wcol_q      <= 1'b0;
            armed_q     <= 1'b0;
            tx_buf_q    <= 8'h00;
            rx_buf_q    <= 8'h00;
            tx_shift_q  <= 8'h00;
            rx_shift_q  <= 8'h00;
            bit_cnt_q   <= 3'd0;
            sck_sync_q  <= '0;
            ss_sync_q   <= '1;
            mosi_sync_q <= '1;
            sck_prev_q  <= 1'b0;
            ss_prev_q   <= 1'b1;
        end else begin
            state_q     <= state_d;
            spcr_q      <= spcr_d;
            spif_q      <= spif_d;
            wcol_q      <= wcol_d;
            armed_q     <= armed_d;
            tx_buf_q    <= tx_buf_d;
            rx_buf_q    <= rx_buf_d;
            tx_shift_q  <= tx_shift_d;
            rx_shift_q  <= rx_shift_d;
            bit_cnt_q   <= bit_cnt_d;
            sck_sync_q  <= sck_sync_d;
            ss_sync_q   <= ss_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sck_prev_q  <= sck_prev_d;
            ss_prev_q   <= ss_prev_d;
        end
    end

    assign miso    = dord ? tx_shift_q[0] : tx_shift_q[7];
    assign miso_oe = spe & ~ss_s;
    assign spi_int = spif_q & spie;

    always_comb begin
        bus_out = 8'h00;
        if (rd) begin
            if (sel_spcr) begin
                bus_out = spcr_q;
            end else if (sel_spsr) begin
                bus_out = {spif_q, wcol_q, 6'b0};
            end else if (sel_spdr) begin
                bus_out = rx_buf_q;
            end
        end
    end

endmodule

// File: tb/tb_atmega_spi_s.sv
module tb_atmega_spi_s;

    localparam int AW     = 6;
    localparam int A_SPCR = 0;
    localparam int A_SPSR = 1;
    localparam int A_SPDR = 2;

    logic          clk = 1'b0;
    logic          rst, wr, rd, int_rst, sck, ss, mosi;
    logic [AW-1:0] addr;
    logic [7:0]    bus_in, bus_out;
    logic          spi_int, miso, miso_oe;

    always #5 clk = ~clk;

    atmega_spi_s #(
        .BUS_ADDR_IO_LEN(AW),
        .SPCR_ADDR(A_SPCR),
        .SPSR_ADDR(A_SPSR),
        .SPDR_ADDR(A_SPDR),
        .SYNC_STAGES(2)
    ) dut (
        .clk(clk), .rst(rst), .addr(addr), .wr(wr), .rd(rd),
        .bus_in(bus_in), .bus_out(bus_out), .spi_int(spi_int), .int_rst(int_rst),
        .sck(sck), .ss(ss), .mosi(mosi), .miso(miso), .miso_oe(miso_oe)
    );

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model of the register-visible state.
    logic [7:0] m_spcr, m_tx, m_rx;
    logic       m_spif, m_wcol, m_armed;
    int         m_bits;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic model_reset();
        m_spcr = 8'h00; m_tx = 8'h00; m_rx = 8'h00;
        m_spif = 1'b0; m_wcol = 1'b0; m_armed = 1'b0; m_bits = 0;
    endtask

    task automatic model_clear_on_access();
        if (m_armed) begin
            m_spif = 1'b0; m_wcol = 1'b0; m_armed = 1'b0;
        end
    endtask

    task automatic bus_write(input int a, input logic [7:0] d);
        addr = a[AW-1:0]; bus_in = d; wr = 1'b1;
        tick(1);
        wr = 1'b0;
        if (a == A_SPCR) begin
            m_spcr = d;
            if (!d[6]) m_bits = 0;
        end else if (a == A_SPDR) begin
            model_clear_on_access();
            if (m_bits != 0) m_wcol = 1'b1;
            else m_tx = d;
        end
    endtask

    task automatic reg_chk(input string tag, input int a);
        logic [7:0] exp, got;
        case (a)
            A_SPCR:  exp = m_spcr;
            A_SPSR:  exp = {m_spif, m_wcol, 6'b0};
            A_SPDR:  exp = m_rx;
            default: exp = 8'h00;
        endcase
        addr = a[AW-1:0]; rd = 1'b1;
        #1 got = bus_out;
        tick(1);
        rd = 1'b0;
        chk(tag, got, exp);
        if (a == A_SPSR && m_spif) m_armed = 1'b1;
        if (a == A_SPDR) model_clear_on_access();
    endtask

    task automatic ss_low();
        ss = 1'b0;
        tick(4);
        m_bits = 0;
        chk("miso_oe_ss_low", miso_oe, m_spcr[6]);
    endtask

    task automatic ss_high();
        ss = 1'b1;
        tick(4);
        m_bits = 0;
        chk("miso_oe_ss_high", miso_oe, 1'b0);
    endtask

    // Master side of one byte (or a partial byte), CPHA=0, sck = clk/8.
    task automatic spi_xfer(input logic [7:0] mbyte, input int nbits,
                            input int coll_at, input bit tcheck);
        logic [7:0] sb, exp_tx;
        logic       cp, dd;
        int         b;
        exp_tx = m_tx; cp = m_spcr[3]; dd = m_spcr[5]; sb = 8'h00;
        for (int i = 0; i < nbits; i++) begin
            b = dd ? i : 7 - i;
            mosi = mbyte[b];
            tick(4);
            sb[b] = miso;
            sck = ~cp;
            m_bits = (i + 1) % 8;
            if (tcheck && i == 7) begin
                tick(2);
                addr = A_SPSR[AW-1:0]; rd = 1'b1;
                #1 chk("spif_before_latency", bus_out[7], 1'b0);
                tick(1);
                chk("spif_at_latency", bus_out[7], 1'b1);
                rd = 1'b0;
                tick(1);
            end else if (i == coll_at) begin
                tick(3);
                bus_write(A_SPDR, 8'h77);
            end else begin
                tick(4);
            end
            sck = cp;
        end
        tick(4);
        if (nbits == 8) begin
            m_rx = mbyte; m_spif = 1'b1;
            chk("miso_byte", sb, exp_tx);
            chk("int_after_byte", spi_int, m_spif & m_spcr[7]);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [7:0] c, t;
        int         nb;
        rst = 1'b1; wr = 1'b0; rd = 1'b0; int_rst = 1'b0;
        sck = 1'b0; ss = 1'b1; mosi = 1'b1; addr = '0; bus_in = 8'h00;
        model_reset();
        tick(3);
        chk("rst_miso_oe", miso_oe, 1'b0);
        chk("rst_miso", miso, 1'b0);
        chk("rst_int", spi_int, 1'b0);
        chk("rst_bus_out", bus_out, 8'h00);
        rst = 1'b0;
        tick(1);
        reg_chk("rst_spcr", A_SPCR);
        reg_chk("rst_spsr", A_SPSR);
        reg_chk("rst_spdr", A_SPDR);

        // Mode 0, MSB first, 0xA5 out / 0x3C in, SPIF latency.
        bus_write(A_SPCR, 8'h40);
        bus_write(A_SPDR, 8'hA5);
        reg_chk("spcr_rb", A_SPCR);
        ss_low();
        spi_xfer(8'h3C, 8, -1, 1'b1);
        ss_high();
        bus_write(A_SPSR, 8'h00);
        reg_chk("spsr_ro", A_SPSR);
        reg_chk("spdr_3c", A_SPDR);
        reg_chk("spsr_cleared", A_SPSR);

        // SPIE, DORD, CPOL: LSB first 0x01, interrupt then clear sequence.
        bus_write(A_SPCR, 8'hE8);
        sck = 1'b1; tick(6);
        bus_write(A_SPDR, 8'($urandom));
        ss_low();
        spi_xfer(8'h01, 8, -1, 1'b0);
        ss_high();
        reg_chk("spsr_e8", A_SPSR);
        reg_chk("spdr_01", A_SPDR);
        chk("int_cleared", spi_int, 1'b0);
        reg_chk("spsr_e8_clr", A_SPSR);

        // Abort after 5 bits, then a full 0x55.
        bus_write(A_SPCR, 8'h40);
        sck = 1'b0; tick(6);
        ss_low();
        spi_xfer(8'($urandom), 5, -1, 1'b0);
        ss_high();
        reg_chk("spsr_abort", A_SPSR);
        reg_chk("spdr_abort", A_SPDR);
        bus_write(A_SPDR, 8'($urandom));
        ss_low();
        spi_xfer(8'h55, 8, -1, 1'b0);
        ss_high();
        reg_chk("spsr_55", A_SPSR);
        reg_chk("spdr_55", A_SPDR);

        // Write collision mid-byte, acknowledged with int_rst.
        bus_write(A_SPDR, 8'($urandom));
        ss_low();
        spi_xfer(8'($urandom), 8, int'($urandom_range(0, 6)), 1'b0);
        reg_chk("spsr_wcol", A_SPSR);
        int_rst = 1'b1; tick(1); int_rst = 1'b0;
        m_spif = 1'b0; m_wcol = 1'b0;
        reg_chk("spsr_int_rst", A_SPSR);
        ss_high();

        // Back-to-back bytes with ss held low.
        bus_write(A_SPDR, 8'($urandom));
        ss_low();
        spi_xfer(8'h12, 8, -1, 1'b0);
        reg_chk("spsr_b2b1", A_SPSR);
        reg_chk("spdr_12", A_SPDR);
        spi_xfer(8'h34, 8, -1, 1'b0);
        reg_chk("spsr_b2b2", A_SPSR);
        reg_chk("spdr_34", A_SPDR);
        ss_high();

        // SPE cleared mid-byte.
        bus_write(A_SPDR, 8'($urandom));
        ss_low();
        spi_xfer(8'($urandom), 3, -1, 1'b0);
        bus_write(A_SPCR, 8'h00);
        chk("miso_oe_spe_off", miso_oe, 1'b0);
        ss_high();
        bus_write(A_SPCR, 8'h40);
        reg_chk("spsr_spe_off", A_SPSR);
        reg_chk("spdr_spe_off", A_SPDR);

        // Randomized modes and data.
        for (int it = 0; it < 10; it++) begin
            c = 8'($urandom);
            c[6] = 1'b1;
            bus_write(A_SPCR, c);
            sck = c[3]; tick(6);
            t = 8'($urandom);
            bus_write(A_SPDR, t);
            ss_low();
            nb = int'($urandom_range(1, 2));
            for (int k = 0; k < nb; k++) begin
                spi_xfer(8'($urandom), 8, -1, 1'b0);
                reg_chk("rnd_spsr", A_SPSR);
                reg_chk("rnd_spdr", A_SPDR);
            end
            ss_high();
        end

        // Reset mid-byte.
        bus_write(A_SPCR, 8'h40);
        sck = 1'b0; tick(6);
        bus_write(A_SPDR, 8'($urandom));
        ss_low();
        spi_xfer(8'($urandom), 4, -1, 1'b0);
        rst = 1'b1; tick(1);
        chk("rst_mid_miso_oe", miso_oe, 1'b0);
        chk("rst_mid_miso", miso, 1'b0);
        chk("rst_mid_int", spi_int, 1'b0);
        rst = 1'b0;
        model_reset();
        reg_chk("rst_mid_spcr", A_SPCR);
        reg_chk("rst_mid_spsr", A_SPSR);
        reg_chk("rst_mid_spdr", A_SPDR);
        ss = 1'b1; tick(4);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/atmega_spi_s.md
ATMEGA_SPI_S -- requirements
Module: atmega_spi_s

Interface
REQ-001 SHALL have parameter BUS_ADDR_IO_LEN, default 6, I/O address width.
REQ-002 SHALL have parameters SPCR_ADDR=0, SPSR_ADDR=1, SPDR_ADDR=2, giving the register offsets.
REQ-003 SHALL have parameter SYNC_STAGES, default 2, synchronizer depth on sck/ss/mosi (min 2).
REQ-004 SHALL use one clock and a synchronous, active-high reset: clk input 1 (system clock, all logic on posedge); rst input 1 (synchronous active-high reset).
REQ-005 SHALL have addr input BUS_ADDR_IO_LEN (register select).
REQ-006 SHALL have wr input 1 (register write strobe) and rd input 1 (register read strobe).
REQ-007 SHALL have bus_in input 8 (write data) and bus_out output 8 (read data, 0 when rd low or addr unmatched).
REQ-008 SHALL have int output 1 (SPIF & SPIE) and int_rst input 1 (interrupt acknowledge).
REQ-009 SHALL have sck input 1, ss input 1 (active low), mosi input 1, miso output 1 and miso_oe output 1 (SPI slave pins; miso_oe = driver enable).

Function
REQ-010 SHALL decode SPCR bits as SPIE=7, SPE=6, DORD=5, CPOL=3; MSTR, CPHA and SPR are stored but ignored (CPHA=0 only).
REQ-011 SHALL define SPSR bits as SPIF=7 and WCOL=6 (both read-only, writes ignored), other bits 0.
REQ-012 SHALL pass sck, ss and mosi through SYNC_STAGES flops, then one edge-detect register; pin-to-internal-event latency SHALL be SYNC_STAGES+1 clk.
REQ-013 SHALL support sck frequency up to clk/8; faster sck is undefined.
REQ-014 SHALL run an FSM with states IDLE and SHIFT.
REQ-015 SHALL go IDLE->SHIFT on synchronized ss falling while SPE=1: bit_cnt=0, tx_shift loaded from tx_buf.
REQ-016 SHALL define leading edge = sck rising when CPOL=0, falling when CPOL=1; trailing edge is the opposite.
REQ-017 SHALL, on a leading edge in SHIFT, sample mosi into rx_shift (MSB-first when DORD=0, LSB-first when DORD=1) and increment bit_cnt.
REQ-018 SHALL, on a trailing edge in SHIFT with bit_cnt 1..7, shift tx_shift so the next bit is on miso.
REQ-019 SHALL, on the 8th leading edge, copy the completed byte into rx_buf in that cycle, set SPIF, reset bit_cnt to 0 and reload tx_shift from tx_buf at the next trailing edge (back-to-back bytes while ss low).
REQ-020 SHALL drive miso = tx_shift[7] (DORD=0) or tx_shift[0] (DORD=1), and miso_oe = SPE & ~ss_sync.
REQ-021 SHALL, on ss rising in SHIFT, return to IDLE, discard a partial byte (no SPIF, rx_buf unchanged) and clear bit_cnt.
REQ-022 SHALL, when SPE is cleared, force IDLE and miso_oe=0 in the next cycle.
REQ-023 SHALL, on an SPDR write in IDLE or with bit_cnt=0, load tx_buf; with bit_cnt 1..7, set WCOL and leave tx_buf unchanged.
REQ-024 SHALL make an SPDR read return rx_buf, combinationally in the rd cycle.
REQ-025 SHALL clear SPIF and WCOL on the first clk after an SPDR access (rd or wr) that follows an SPSR read with SPIF=1; int_rst clears SPIF immediately.
REQ-026 SHALL give set priority to simultaneous SPIF set and clear: SPIF ends at 1.
REQ-027 SHALL clear WCOL on the same conditions as SPIF.
REQ-028 SHALL allow SPCR writes at any time; DORD/CPOL changes mid-byte are undefined.

Reset
REQ-029 SHALL, on rst=1 at posedge clk: SPCR=0x00, SPSR=0x00, tx_buf=0x00, rx_buf=0x00, rx_shift=0x00, tx_shift=0x00, bit_cnt=0, FSM=IDLE, synchronizers=idle pin levels (sck=CPOL0 level 0, ss=1, mosi=1).
REQ-030 SHALL hold outputs during and after reset at int=0, miso=0, miso_oe=0, bus_out=0.
REQ-031 SHALL abort a transfer on reset mid-byte with no SPIF.

Verification
REQ-032 SPCR=0x40, SPDR write 0xA5, master (mode 0, clk/8) sends 0x3C with ss low -> miso carries 10100101 MSB-first, rx_buf=0x3C, SPIF=1 after the 8th rising edge + 3 clk.
REQ-033 SPCR=0xE8 (SPIE, DORD, CPOL), master sends 0x01 LSB-first -> rx_buf=0x01, int=1; SPSR read then SPDR read -> SPIF=0, int=0.
REQ-034 ss raised after 5 bits -> FSM IDLE, SPIF=0, rx_buf unchanged, next full byte 0x55 received correctly.
REQ-035 SPDR write 0x77 after 3 bits -> WCOL=1, miso continues the previous tx_buf byte; int_rst -> SPIF=0, WCOL=0.
REQ-036 Two back-to-back bytes 0x12, 0x34 with ss held low -> SPIF set twice, rx_buf=0x34 at the end.
REQ-037 rst asserted mid-byte -> all registers at reset values next clk, miso_oe=0, no SPIF.
